// File: rtl/mac_tx_arb_pkg.sv
// Shared types and constants for the MAC transmit arbiter and its round-robin encoder.
package mac_tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
    localparam int MAX_REQ        = 8;
    localparam int PKT_CNT_W      = 32;

    // Width of an index into n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_rr_grant.sv
// Combinational round-robin priority encoder: picks the first asserted request
// at or after ptr, wrapping cyclically.
module rr_grant
    import mac_tx_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int   cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 10G MAC TX stream.
// Optional per-requester packet counters: define MAC_TX_ARB_PKT_COUNT_EN.
module mac_tx_arbiter
    import mac_tx_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0] in_tkeep,
    input  logic [NUM_REQ-1:0]            in_tvalid,
    input  logic [NUM_REQ-1:0]            in_tlast,
    output logic [NUM_REQ-1:0]            in_tready,
    output logic [DATA_WIDTH-1:0]         out_tdata,
    output logic [KEEP_WIDTH-1:0]         out_tkeep,
    output logic                          out_tvalid,
    output logic                          out_tlast,
    input  logic                          out_tready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
`ifdef MAC_TX_ARB_PKT_COUNT_EN
    ,
    output logic [NUM_REQ*PKT_CNT_W-1:0]  pkt_count,
    input  logic                          pkt_count_clr
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 pkt_end;

    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];
    logic [KEEP_WIDTH-1:0] keep_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_slice[gi] = in_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign keep_slice[gi] = in_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
            assign in_tready[gi]  = (state_reg == BUSY) && grant_reg[gi] && out_tready;
        end
    endgenerate

    rr_grant #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req (in_tvalid),
        .ptr (rr_ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // The owner's stream is forwarded without a register stage.
    always_comb begin
        out_tdata  = '0;
        out_tkeep  = '0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        if (state_reg == BUSY) begin
            out_tdata  = data_slice[idx_reg];
            out_tkeep  = keep_slice[idx_reg];
            out_tvalid = in_tvalid[idx_reg];
            out_tlast  = in_tlast[idx_reg];
        end
    end

    assign pkt_end = out_tvalid && out_tready && out_tlast;

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        idx_next    = idx_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    grant_next = arb_gnt;
                    idx_next   = arb_idx;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Grant is only released on the final handshake, so a stalled
                // or paused packet keeps its owner.
                if (pkt_end) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    rr_ptr_next = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            idx_reg    <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            idx_reg    <= idx_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign grant = grant_reg;
    assign busy  = (state_reg == BUSY);

`ifdef MAC_TX_ARB_PKT_COUNT_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            logic [PKT_CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (pkt_count_clr) begin
                    cnt_reg <= '0;
                end else if (in_tvalid[gi] && in_tready[gi] && in_tlast[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign pkt_count[gi*PKT_CNT_W +: PKT_CNT_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the single 10G MAC transmit stream (156.25 MHz domain) among NUM_REQ on-chip packet sources, e.g. PCIe bridge DMA and a diagnostics generator.
- Sits between the sources and the MAC TX AXI-stream input in the SoC wrapper.
- Guarantees packets are never interleaved.
- Gives fair access: each requester gets at most one packet per round.

Parameters:
NUM_REQ, 4, number of requesting streams (2..8)
DATA_WIDTH, 64, stream data width in bits
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width

Ports:
clk  in  1  156.25 MHz stream clock
rst  in  1  asynchronous active-high reset
in_tdata  in  NUM_REQ*DATA_WIDTH  requester data; requester i occupies slice i
in_tkeep  in  NUM_REQ*KEEP_WIDTH  requester byte enables
in_tvalid  in  NUM_REQ  per-requester valid
in_tlast  in  NUM_REQ  per-requester end of packet
in_tready  out  NUM_REQ  per-requester ready
out_tdata  out  DATA_WIDTH  to MAC
out_tkeep  out  KEEP_WIDTH  to MAC
out_tvalid  out  1  to MAC
out_tlast  out  1  to MAC
out_tready  in  1  from MAC
grant  out  NUM_REQ  one-hot current owner; 0 when idle
busy  out  1  high while a packet is in flight

Behaviour:
- Reset values: in_tready=0, out_tvalid=0, out_tlast=0, out_tdata=0, out_tkeep=0, grant=0, busy=0.
- Reset values (internal): state=IDLE, round-robin pointer rr_ptr=0.
- Reset is asynchronous. Asserting it mid-packet drops the grant immediately; the partial packet is abandoned.
- States: IDLE and BUSY.
- IDLE:
  - All in_tready=0; out_tvalid=0.
  - If any in_tvalid is high, select the first requester at or after rr_ptr, cyclically.
  - Register its one-hot grant, set busy=1, go to BUSY next cycle. Arbitration costs exactly one bubble cycle.
- BUSY, with g = granted index:
  - Forwarding is combinational: out_tdata/tkeep/tvalid/tlast = slice g of the inputs.
  - in_tready[g] = out_tready; all other in_tready = 0.
  - Zero added latency.
- BUSY exit: on the cycle out_tvalid & out_tready & out_tlast:
  - next state IDLE, grant=0, busy=0.
  - rr_ptr = (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- BUSY hold:
  - If the granted source drops tvalid mid-packet, the grant is held indefinitely; out_tvalid follows it low.
  - Other requesters wait.
- Handshake rules:
  - A source must hold tdata/tkeep/tlast stable while tvalid=1 and tready=0 (AXI-stream rules).
  - The arbiter never changes grant while a beat is stalled.
- Single-beat packet (tvalid & tlast on first beat): BUSY lasts exactly one handshake cycle.
- No requesters valid in IDLE: stay in IDLE, rr_ptr unchanged.
- Simultaneous requests: resolved purely by rr_ptr.
- A new in_tvalid arriving during BUSY is only considered at the next IDLE cycle.
- tkeep is passed unmodified; no checking of tkeep contiguity.

Optional Feature:
- Macro: MAC_TX_ARB_PKT_COUNT_EN.
- When defined:
  - Adds output pkt_count, NUM_REQ*32 bits, one 32-bit counter per requester.
  - Counter i increments on each tlast handshake from requester i and wraps from 0xFFFFFFFF to 0.
  - Reset value 0.
  - Adds input pkt_count_clr, 1 bit; a synchronous pulse zeroes all counters.
  - If pkt_count_clr coincides with an increment, clear wins.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mac_tx_arb_pkg:
  - state enum {IDLE, BUSY}
  - DATA_WIDTH/KEEP_WIDTH defaults
  - MAX_REQ=8
  - counter width constant PKT_CNT_W=32
- Sub-module rr_grant:
  - Combinational round-robin priority encoder.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Instantiated once, reusable by other arbiters.

Test Plan:
- Reset then in_tvalid=4'b0001, 3-beat packet, out_tready=1:
  - grant=0001 one cycle after tvalid.
  - out carries beats 1..3 with tlast on beat 3.
  - grant=0 the next cycle; rr_ptr=1.
- All four requesters valid continuously with 2-beat packets:
  - grant order 0001, 0010, 0100, 1000, 0001.
  - One idle bubble between packets; no interleaving.
- Granted requester 2 deasserts tvalid for 5 cycles mid-packet while requester 0 is valid:
  - grant stays 0100 and in_tready[0]=0 throughout.
  - Packet completes intact.
- Backpressure: out_tready toggles 1,0,0,1 on a 4-beat packet:
  - each beat is transferred exactly once.
  - in_tready[g] mirrors out_tready each cycle.
- rst asserted mid-packet on beat 2:
  - out_tvalid, in_tready and grant fall to 0 immediately.
  - After release, requester 0 is granted first (rr_ptr=0).
- With MAC_TX_ARB_PKT_COUNT_EN: send 3 packets from requester 1 and 1 from requester 3:
  - pkt_count slice 1 = 3, slice 3 = 1.
  - A pkt_count_clr pulse zeroes all slices on the following cycle.
